// File: rtl/cbfp_pkg.sv
// Shared types and default parameters for the CBFP block normaliser.
package cbfp_pkg;

    // Life cycle of one ping-pong bank.
    typedef enum logic [2:0] {
        EMPTY,
        FILLING,
        FINAL,
        FULL,
        DRAINING
    } bank_state_t;

    // Exponent sharing mode, latched per block.
    typedef enum logic {
        BLOCK,
        LANE
    } cbfp_mode_t;

    localparam int unsigned DEF_LANES     = 16;
    localparam int unsigned DEF_IN_W      = 25;
    localparam int unsigned DEF_OUT_W     = 12;
    localparam int unsigned DEF_BLK_BEATS = 4;
    localparam int unsigned DEF_IDX_W     = 5;

endpackage

// File: rtl/cbfp_lsc.sv
// Leading-sign count: number of bits directly below the sign bit that equal it.
module cbfp_lsc #(
    parameter int unsigned W  = 25,
    parameter int unsigned CW = 5
) (
    input  logic [W-1:0]  x_i,
    output logic [CW-1:0] cnt_o
);

    logic run;

    // Walk down from just below the sign bit, stopping at the first differing bit.
    always_comb begin
        cnt_o = '0;
        run   = 1'b1;
        for (int i = int'(W) - 2; i >= 0; i--) begin
            if (run && (x_i[i] == x_i[W-1])) begin
                cnt_o = cnt_o + 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cbfp_block_norm.sv
// Ping-pong CBFP normaliser: buffers a block, finds the shared left-shift exponent,
// then replays the block shifted, rounded and saturated to OUT_W bits.
module cbfp_block_norm
    import cbfp_pkg::*;
#(
    parameter int unsigned LANES     = DEF_LANES,
    parameter int unsigned IN_W      = DEF_IN_W,
    parameter int unsigned OUT_W     = DEF_OUT_W,
    parameter int unsigned BLK_BEATS = DEF_BLK_BEATS,
    parameter int unsigned IDX_W     = DEF_IDX_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_lane_mode,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES-1:0][IN_W-1:0]       din_re,
    input  logic [LANES-1:0][IN_W-1:0]       din_im,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES-1:0][OUT_W-1:0]      dout_re,
    output logic [LANES-1:0][OUT_W-1:0]      dout_im,
    output logic [LANES-1:0][IDX_W-1:0]      idx,
    output logic                             out_last
);

    localparam int unsigned D  = IN_W - OUT_W;
    localparam int unsigned BW = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BLK_BEATS - 1);
    localparam logic signed [IN_W:0] RND    = (IN_W + 1)'(2 ** (D - 1));
    localparam logic signed [IN_W:0] SAT_HI = (IN_W + 1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W:0] SAT_LO = ~SAT_HI;

    typedef logic [LANES-1:0][IN_W-1:0]  beat_t;
    typedef logic [LANES-1:0][IDX_W-1:0] lane_idx_t;

    // Shift, round half-up and clamp one component; one guard bit absorbs rounding carry.
    function automatic logic [OUT_W-1:0] norm(input logic [IN_W-1:0] x,
                                              input logic [IDX_W-1:0] s);
        logic signed [IN_W:0] v;
        v = $signed({x[IN_W-1], x}) <<< s;
        v = (v + RND) >>> D;
        if (v > SAT_HI) begin
            v = SAT_HI;
        end else if (v < SAT_LO) begin
            v = SAT_LO;
        end
        return v[OUT_W-1:0];
    endfunction

    lane_idx_t lsc_re, lsc_im, beat_min;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        cbfp_lsc #(.W(IN_W), .CW(IDX_W)) u_lsc_re (.x_i(din_re[l]), .cnt_o(lsc_re[l]));
        cbfp_lsc #(.W(IN_W), .CW(IDX_W)) u_lsc_im (.x_i(din_im[l]), .cnt_o(lsc_im[l]));
        assign beat_min[l] = (lsc_re[l] < lsc_im[l]) ? lsc_re[l] : lsc_im[l];
    end

    bank_state_t      state_q [2];
    bank_state_t      state_d [2];
    cbfp_mode_t       mode_q  [2];
    cbfp_mode_t       mode_d  [2];
    lane_idx_t        emin_q  [2];
    lane_idx_t        emin_d  [2];
    lane_idx_t        shift_q [2];
    lane_idx_t        shift_d [2];
    logic [IDX_W-1:0] blk_min [2];
    beat_t            mem_re_q [2][BLK_BEATS];
    beat_t            mem_re_d [2][BLK_BEATS];
    beat_t            mem_im_q [2][BLK_BEATS];
    beat_t            mem_im_d [2][BLK_BEATS];

    logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [BW-1:0] wr_beat_q, wr_beat_d, rd_beat_q, rd_beat_d;
    logic          wr_fire, rd_fire, wr_last, rd_last;

    assign in_ready  = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILLING);
    assign out_valid = (state_q[rd_bank_q] == FULL) || (state_q[rd_bank_q] == DRAINING);
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign wr_last   = (wr_beat_q == LAST_BEAT);
    assign rd_last   = (rd_beat_q == LAST_BEAT);

    // Lane-to-block minimum of each bank's running lane exponents.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            blk_min[b] = emin_q[b][0];
            for (int l = 1; l < int'(LANES); l++) begin
                if (emin_q[b][l] < blk_min[b]) blk_min[b] = emin_q[b][l];
            end
        end
    end

    // Bank life cycle, pointer advance, running minima and sample capture.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        emin_d    = emin_q;
        shift_d   = shift_q;
        mem_re_d  = mem_re_q;
        mem_im_d  = mem_im_q;
        wr_bank_d = wr_bank_q;
        wr_beat_d = wr_beat_q;
        rd_bank_d = rd_bank_q;
        rd_beat_d = rd_beat_q;

        for (int b = 0; b < 2; b++) begin
            if (state_q[b] == FINAL) begin
                for (int l = 0; l < int'(LANES); l++) begin
                    shift_d[b][l] = (mode_q[b] == LANE) ? emin_q[b][l] : blk_min[b];
                end
                state_d[b] = FULL;
            end
        end

        if (wr_fire) begin
            mem_re_d[wr_bank_q][wr_beat_q] = din_re;
            mem_im_d[wr_bank_q][wr_beat_q] = din_im;
            if (wr_beat_q == '0) begin
                // First beat seeds the minima and latches the mode for the whole block.
                emin_d[wr_bank_q] = beat_min;
                mode_d[wr_bank_q] = cbfp_mode_t'(cfg_lane_mode);
            end else begin
                for (int l = 0; l < int'(LANES); l++) begin
                    if (beat_min[l] < emin_q[wr_bank_q][l]) emin_d[wr_bank_q][l] = beat_min[l];
                end
            end
            if (wr_last) begin
                state_d[wr_bank_q] = FINAL;
                wr_beat_d          = '0;
                wr_bank_d          = ~wr_bank_q;
            end else begin
                state_d[wr_bank_q] = FILLING;
                wr_beat_d          = wr_beat_q + 1'b1;
            end
        end

        if (rd_fire) begin
            if (rd_last) begin
                state_d[rd_bank_q] = EMPTY;
                rd_beat_d          = '0;
                rd_bank_d          = ~rd_bank_q;
            end else begin
                state_d[rd_bank_q] = DRAINING;
                rd_beat_d          = rd_beat_q + 1'b1;
            end
        end
    end

    // Control state with synchronous reset; reset abandons any partial or buffered block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= '{default: EMPTY};
            mode_q    <= '{default: BLOCK};
            emin_q    <= '{default: '0};
            shift_q   <= '{default: '0};
            wr_bank_q <= 1'b0;
            wr_beat_q <= '0;
            rd_bank_q <= 1'b0;
            rd_beat_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            emin_q    <= emin_d;
            shift_q   <= shift_d;
            wr_bank_q <= wr_bank_d;
            wr_beat_q <= wr_beat_d;
            rd_bank_q <= rd_bank_d;
            rd_beat_q <= rd_beat_d;
        end
    end

    // Sample storage; only observed while out_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_re_q <= mem_re_d;
        mem_im_q <= mem_im_d;
    end

    // Output payload muxed straight from the read bank; zero whenever nothing is valid.
    always_comb begin
        dout_re  = '0;
        dout_im  = '0;
        idx      = '0;
        out_last = 1'b0;
        if (out_valid) begin
            for (int l = 0; l < int'(LANES); l++) begin
                dout_re[l] = norm(mem_re_q[rd_bank_q][rd_beat_q][l], shift_q[rd_bank_q][l]);
                dout_im[l] = norm(mem_im_q[rd_bank_q][rd_beat_q][l], shift_q[rd_bank_q][l]);
            end
            idx      = shift_q[rd_bank_q];
            out_last = rd_last;
        end
    end

endmodule
